// File: rtl/tpa_pkg.sv
// Shared widths, command encodings and grant/state encoding for the TPA
// register arbiter and its register file.
package tpa_pkg;

  localparam int TPA_ADDR_W = 8;
  localparam int TPA_DATA_W = 16;

  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE_RIM = 2'd1,
    SERVE_TWM = 2'd2
  } grant_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/tpa_regfile.sv
// TPA register storage: one synchronous write port, one synchronous read
// port with registered read data; contents are intentionally not reset.
module tpa_regfile
  import tpa_pkg::*;
#(
  parameter int ADDR_W = TPA_ADDR_W,
  parameter int DATA_W = TPA_DATA_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_reg [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_reg <= mem_reg[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/tpa_reg_arbiter.sv
// Arbitrates single-word RIM and TWM accesses onto one shared register file;
// the registered grant record produces the one-cycle rdy pulses.
module tpa_reg_arbiter
  import tpa_pkg::*;
#(
  parameter int ADDR_W    = TPA_ADDR_W,
  parameter int DATA_W    = TPA_DATA_W,
  parameter int PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rim_req,
  input  logic              rim_cmd,
  input  logic [ADDR_W-1:0] rim_addr,
  input  logic [DATA_W-1:0] rim_wdata,
  output logic              rim_rdy,
  output logic [DATA_W-1:0] rim_rdata,
  input  logic              twm_req,
  input  logic              twm_cmd,
  input  logic [ADDR_W-1:0] twm_addr,
  input  logic [DATA_W-1:0] twm_wdata,
  output logic              twm_rdy,
  output logic [DATA_W-1:0] twm_rdata,
  output logic [7:0]        conflict_cnt
);

  grant_e            state_reg, state_next;
  logic              twm_last_reg, twm_last_next;
  logic              rd_pending_reg;
  logic [7:0]        conflict_cnt_reg;
  logic [1:0]        rdy_vec;
  logic              rim_elig, twm_elig, contend;
  logic              acc_valid, acc_cmd;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] rdata_vec [2];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      twm_last_reg     <= 1'b1;  // RIM wins the first tie after reset
      rd_pending_reg   <= 1'b0;
      conflict_cnt_reg <= 8'd0;
    end else begin
      state_reg        <= state_next;
      twm_last_reg     <= twm_last_next;
      rd_pending_reg   <= acc_valid && (acc_cmd == CMD_READ);
      conflict_cnt_reg <= contend ? sat_inc8(conflict_cnt_reg) : conflict_cnt_reg;
    end
  end

  // The rdy cycle masks the requester so a held req is not served twice.
  always_comb begin
    rim_elig      = rim_req && !rdy_vec[0];
    twm_elig      = twm_req && !rdy_vec[1];
    contend       = rim_elig && twm_elig;
    state_next    = IDLE;
    twm_last_next = twm_last_reg;
    if (contend) begin
      if (PRIO_MODE != 0) begin
        state_next = SERVE_TWM;
      end else begin
        state_next = twm_last_reg ? SERVE_RIM : SERVE_TWM;
      end
    end else if (rim_elig) begin
      state_next = SERVE_RIM;
    end else if (twm_elig) begin
      state_next = SERVE_TWM;
    end
    if (state_next != IDLE) begin
      twm_last_next = (state_next == SERVE_TWM);
    end
  end

  always_comb begin
    rdy_vec = 2'b00;
    case (state_reg)
      SERVE_RIM: rdy_vec[0] = 1'b1;
      SERVE_TWM: rdy_vec[1] = 1'b1;
      default:   rdy_vec    = 2'b00;
    endcase
  end

  always_comb begin
    acc_valid = (state_next != IDLE);
    acc_cmd   = rim_cmd;
    acc_addr  = rim_addr;
    acc_wdata = rim_wdata;
    if (state_next == SERVE_TWM) begin
      acc_cmd   = twm_cmd;
      acc_addr  = twm_addr;
      acc_wdata = twm_wdata;
    end
  end

  // Gating the write with reset_n drops an access granted in a reset cycle.
  tpa_regfile #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk     (clk),
    .wr_en   (acc_valid && (acc_cmd == CMD_WRITE) && reset_n),
    .wr_addr (acc_addr),
    .wr_data (acc_wdata),
    .rd_en   (acc_valid && (acc_cmd == CMD_READ)),
    .rd_addr (acc_addr),
    .rd_data (rd_data)
  );

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [DATA_W-1:0] hold_reg;
    logic              show;

    assign show = rdy_vec[gi] && rd_pending_reg;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        hold_reg <= '0;
      end else if (show) begin
        hold_reg <= rd_data;
      end
    end

    assign rdata_vec[gi] = show ? rd_data : hold_reg;
  end

  assign rim_rdy      = rdy_vec[0];
  assign twm_rdy      = rdy_vec[1];
  assign rim_rdata    = rdata_vec[0];
  assign twm_rdata    = rdata_vec[1];
  assign conflict_cnt = conflict_cnt_reg;

endmodule
